// File: rtl/hw_config_pkg.sv
// hw_config_pkg: shared hardware configuration for the data-memory side.
//   mem_word_t          - one data-memory row, N_BANKS lanes of BIT_L bits
//   mem_addr_t          - data-memory row address
//   DATA_MEM_*          - data-memory geometry and fixed read latency
//   LOADER_FIFO_DEPTH   - default return-buffer depth of data_mem_loader
//   loader_state_t      - data_mem_loader control states
package hw_config_pkg;

  localparam int BIT_L               = 8;
  localparam int N_BANKS             = 4;
  localparam int DATA_MEM_ADDR_L     = 8;
  localparam int DATA_MEM_RD_LATENCY = 2;
  localparam int LOADER_FIFO_DEPTH   = 4;

  typedef logic [N_BANKS-1:0][BIT_L-1:0] mem_word_t;
  typedef logic [DATA_MEM_ADDR_L-1:0]    mem_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/mem_word_fifo.sv
// mem_word_fifo: synchronous FIFO of mem_word_t rows with registered head.
//   clk, rst   - clock, asynchronous active-high reset (control only)
//   i_push     - write i_wr_data (dropped if full and not popping)
//   i_wr_data  - row to write
//   i_pop      - consume the head row (ignored when empty)
//   o_vld      - head row valid (registered)
//   o_data     - head row (registered, not reset)
//   o_count    - rows currently held
module mem_word_fifo
  import hw_config_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  mem_word_t        i_wr_data,
  input  logic             i_pop,
  output logic             o_vld,
  output mem_word_t        o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_word_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_vld;
  mem_word_t        r_data;

  logic             w_pop, w_push;
  logic [PTR_W-1:0] w_rd_ptr_n;
  logic [CNT_W-1:0] w_cnt_after_pop, w_count_n;
  mem_word_t        w_head_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop           = i_pop & r_vld;
  assign w_push          = i_push & ((r_count < CNT_W'(DEPTH)) | w_pop);
  assign w_rd_ptr_n      = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_n       = w_cnt_after_pop + CNT_W'(w_push);
  // When nothing older survives the pop, the incoming row becomes the head
  // directly; otherwise the next stored row does.
  assign w_head_n        = (w_cnt_after_pop == '0) ? i_wr_data : r_mem[w_rd_ptr_n];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_n;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_count  <= w_count_n;
      r_vld    <= (w_count_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_count_n != '0) r_data <= w_head_n;
  end

  assign o_vld   = r_vld;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/data_mem_loader.sv
// data_mem_loader: streams n_rows consecutive data-memory rows starting at
// base_addr to the register-bank write stage, with flow control.
//   clk, rst                - clock, asynchronous active-high reset
//   start, base_addr, n_rows- block load request (taken only in IDLE)
//   busy, done              - not-IDLE flag, one-cycle completion pulse
//   mem_rd_en, mem_rd_addr  - data-memory read port (data RD_LAT cycles later)
//   mem_rd_data             - data-memory read data
//   out_vld/out_rdy         - row handshake to the write stage
//   out_data, out_idx       - row data (lane b -> bank b), row offset
module data_mem_loader
  import hw_config_pkg::*;
#(
  parameter int ADDR_L     = DATA_MEM_ADDR_L,
  parameter int RD_LAT     = DATA_MEM_RD_LATENCY,
  parameter int FIFO_DEPTH = LOADER_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_L-1:0] base_addr,
  input  logic [ADDR_L:0]   n_rows,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_L-1:0] mem_rd_addr,
  input  mem_word_t         mem_rd_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output mem_word_t         out_data,
  output logic [ADDR_L-1:0] out_idx
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_L:0] ROW_ONE = {{ADDR_L{1'b0}}, 1'b1};

  logic              r_start_p0;
  logic [ADDR_L-1:0] r_base_p0;
  logic [ADDR_L:0]   r_nrows_p0;

  loader_state_t     r_state, w_state_n;
  logic [ADDR_L-1:0] r_base;
  logic [ADDR_L:0]   r_nrows, r_issued, r_accepted;
  logic [RD_LAT-1:0] r_inflight;

  logic              w_pop, w_room, w_rd_en, w_done;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [OCC_W-1:0]  w_occ;

  function automatic logic [OCC_W-1:0] popcnt(input logic [RD_LAT-1:0] v);
    popcnt = '0;
    for (int i = 0; i < RD_LAT; i++) popcnt = popcnt + OCC_W'(v[i]);
  endfunction

  // ---- p0: request capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_start_p0 <= 1'b0;
    else     r_start_p0 <= start;
  end

  always_ff @(posedge clk) begin
    r_base_p0  <= base_addr;
    r_nrows_p0 <= n_rows;
  end

  // ---- p1: read issue control ----
  assign w_pop  = out_vld & out_rdy;
  // Every issued read owns a FIFO slot from issue until its row is accepted.
  assign w_occ  = OCC_W'(w_fifo_count) + popcnt(r_inflight) - OCC_W'(w_pop);
  assign w_room = (w_occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    w_state_n = r_state;
    w_rd_en   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_start_p0) w_state_n = (r_nrows_p0 == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        if (w_room) begin
          w_rd_en = 1'b1;
          if (r_issued + ROW_ONE == r_nrows) w_state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && (r_accepted + ROW_ONE == r_nrows)) w_state_n = FIN;
      end
      FIN: begin
        w_done    = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_nrows    <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= (r_inflight << 1) | RD_LAT'(w_rd_en);
      if (r_state == IDLE && r_start_p0) begin
        r_base     <= r_base_p0;
        r_nrows    <= r_nrows_p0;
        r_issued   <= '0;
        r_accepted <= '0;
      end
      if (w_rd_en) r_issued   <= r_issued + ROW_ONE;
      if (w_pop)   r_accepted <= r_accepted + ROW_ONE;
    end
  end

  // ---- p2: return buffer, row written as its in-flight bit emerges ----
  mem_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (r_inflight[RD_LAT-1]),
    .i_wr_data (mem_rd_data),
    .i_pop     (out_rdy),
    .o_vld     (out_vld),
    .o_data    (out_data),
    .o_count   (w_fifo_count)
  );

  assign busy        = (r_state != IDLE);
  assign done        = w_done;
  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = r_base + r_issued[ADDR_L-1:0];
  assign out_idx     = r_accepted[ADDR_L-1:0];

endmodule

// File: tb/tb_data_mem_loader.sv
// tb_data_mem_loader: directed bench for data_mem_loader with a behavioural
// fixed-latency data memory and an in-order row/address scoreboard.
module tb_data_mem_loader;
  import hw_config_pkg::*;

  localparam int ADDR_L = DATA_MEM_ADDR_L;
  localparam int RD_LAT = DATA_MEM_RD_LATENCY;
  localparam int DEPTH  = LOADER_FIFO_DEPTH;

  logic              clk, rst, start;
  logic [ADDR_L-1:0] base_addr;
  logic [ADDR_L:0]   n_rows;
  logic              busy, done, mem_rd_en;
  logic [ADDR_L-1:0] mem_rd_addr;
  mem_word_t         mem_rd_data;
  logic              out_vld, out_rdy;
  mem_word_t         out_data;
  logic [ADDR_L-1:0] out_idx;

  data_mem_loader #(
    .ADDR_L     (ADDR_L),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .n_rows      (n_rows),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .out_idx     (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents depend on address and an epoch that changes at reset,
  // so rows fetched before a reset are distinguishable from later ones.
  logic [7:0] epoch;

  function automatic mem_word_t mem_word(input logic [ADDR_L-1:0] a, input logic [7:0] e);
    logic [7:0] a8;
    a8 = 8'(a);
    return {a8 ^ e, ~a8, e, a8 + 8'h3C};
  endfunction

  mem_word_t rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? mem_word(mem_rd_addr, epoch) : '0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic [ADDR_L-1:0] idx;
    mem_word_t         data;
  } row_t;

  row_t              sb_q [$];
  logic [ADDR_L-1:0] addr_q [$];

  int n_assert, n_fail;
  int cyc, start_cyc;
  int rd_cnt, pop_cnt, done_cnt;
  int first_rd, last_rd, first_pop, last_pop, done_cyc;
  logic              hold_prev;
  mem_word_t         prev_data;
  logic [ADDR_L-1:0] prev_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
    first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
    hold_prev = 1'b0;
  endtask

  task automatic load(input int base, input int n);
    logic [ADDR_L-1:0] a;
    row_t r;
    base_addr = ADDR_L'(base);
    n_rows    = (ADDR_L+1)'(n);
    for (int i = 0; i < n; i++) begin
      a = ADDR_L'(base + i);
      addr_q.push_back(a);
      r.idx  = ADDR_L'(i);
      r.data = mem_word(a, epoch);
      sb_q.push_back(r);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe.
  task automatic tick(input logic s, input logic r);
    logic pop;
    row_t e;
    @(negedge clk);
    start   = s;
    out_rdy = r;
    #1;
    cyc++;
    if (s) start_cyc = cyc;
    pop = out_vld & out_rdy;
    if (hold_prev) begin
      check("hold_vld",  64'(out_vld),  64'(1));
      check("hold_data", 64'(out_data), 64'(prev_data));
      check("hold_idx",  64'(out_idx),  64'(prev_idx));
    end
    hold_prev = out_vld & ~out_rdy;
    prev_data = out_data;
    prev_idx  = out_idx;
    if (mem_rd_en) begin
      check("rd_room", 64'((rd_cnt - pop_cnt - int'(pop)) < DEPTH), 64'(1));
      check("rd_expected", 64'(addr_q.size() != 0), 64'(1));
      if (addr_q.size() != 0) check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
      if (rd_cnt == 0) first_rd = cyc;
      last_rd = cyc;
      rd_cnt++;
    end
    if (pop) begin
      check("row_expected", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_idx",  64'(out_idx),  64'(e.idx));
      end
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // mode 0: out_rdy=1, mode 1: out_rdy=0, mode 2: random out_rdy
  task automatic run_until_done(input int budget, input int mode);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      if (mode == 0)      tick(1'b0, 1'b1);
      else if (mode == 1) tick(1'b0, 1'b0);
      else                tick(1'b0, 1'($urandom_range(0, 1)));
    end
    check("done_seen", 64'(done_cnt), 64'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    64'(busy),        64'(0));
    check({tag, "_done"},    64'(done),        64'(0));
    check({tag, "_rd_en"},   64'(mem_rd_en),   64'(0));
    check({tag, "_out_vld"}, 64'(out_vld),     64'(0));
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'(0));
    check({tag, "_out_idx"}, 64'(out_idx),     64'(0));
  endtask

  task automatic check_load(input string tag, input int n);
    check({tag, "_reads"}, 64'(rd_cnt),      64'(n));
    check({tag, "_rows"},  64'(pop_cnt),     64'(n));
    check({tag, "_left"},  64'(sb_q.size()), 64'(0));
    check({tag, "_done"},  64'(done_cnt),    64'(1));
  endtask

  initial begin
    logic [ADDR_L-1:0] top2;
    n_assert = 0; n_fail = 0; cyc = 0; start_cyc = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; n_rows = '0; out_rdy = 1'b0;
    epoch = 8'h11;
    clear_stats();

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick(1'b0, 1'b1);

    // base 0x10, 4 rows, always ready
    clear_stats();
    load(32'h10, 4);
    tick(1'b1, 1'b1);
    run_until_done(40, 0);
    repeat (3) tick(1'b0, 1'b1);
    check_load("basic", 4);
    check("basic_rd_span",   64'(last_rd - first_rd),   64'(3));
    check("basic_pop_span",  64'(last_pop - first_pop), 64'(3));
    check("basic_done_lag",  64'(done_cyc - last_pop),  64'(1));

    // address wrap at the top of the row space
    clear_stats();
    top2 = '1;
    top2 = top2 - 1'b1;
    load(int'(top2), 4);
    tick(1'b1, 1'b1);
    run_until_done(40, 0);
    repeat (2) tick(1'b0, 1'b1);
    check_load("wrap", 4);

    // 20-cycle output stall: reads must stop at the buffer depth
    clear_stats();
    load(32'h40, 8);
    tick(1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
    check("stall_reads", 64'(rd_cnt),  64'(DEPTH));
    check("stall_rows",  64'(pop_cnt), 64'(0));
    check("stall_busy",  64'(busy),    64'(1));
    run_until_done(80, 0);
    repeat (2) tick(1'b0, 1'b1);
    check_load("stall", 8);

    // empty load
    clear_stats();
    n_rows = '0;
    base_addr = ADDR_L'(32'h33);
    tick(1'b1, 1'b1);
    run_until_done(10, 0);
    repeat (2) tick(1'b0, 1'b1);
    check("empty_reads",    64'(rd_cnt),               64'(0));
    check("empty_done_lag", 64'(done_cyc - start_cyc), 64'(2));
    check("empty_done_cnt", 64'(done_cnt),             64'(1));

    // start held high into the busy period starts only one load
    clear_stats();
    load(32'h80, 3);
    repeat (6) tick(1'b1, 1'b1);
    check("held_busy", 64'(busy), 64'(1));
    run_until_done(40, 0);
    repeat (10) tick(1'b0, 1'b1);
    check_load("held", 3);

    // reset in the middle of a 16-row load
    clear_stats();
    load(32'h20, 16);
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    addr_q.delete();
    sb_q.delete();
    epoch = 8'h5A;
    repeat (2) tick(1'b0, 1'b1);
    rst = 1'b0;
    clear_stats();
    repeat (2) tick(1'b0, 1'b1);
    load(32'h20, 2);
    tick(1'b1, 1'b1);
    run_until_done(40, 0);
    repeat (3) tick(1'b0, 1'b1);
    check_load("postrst", 2);

    // 100 rows under random backpressure
    clear_stats();
    load(32'h90, 100);
    tick(1'b1, 1'b1);
    run_until_done(2000, 2);
    repeat (5) tick(1'b0, 1'b1);
    check_load("random", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_loader.md
DATA_MEM_LOADER -- requirements
Module: data_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_L, default DATA_MEM_ADDR_L; data-memory row address width.
REQ-002 SHALL have parameter RD_LAT, default DATA_MEM_RD_LATENCY; fixed data-memory read latency in cycles (1..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; return-buffer depth in mem_word_t rows, at least RD_LAT+2.
REQ-004 SHALL have port clk, input, 1; the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1; reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1; requests a block load, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_L; first row address, sampled with start.
REQ-008 SHALL have port n_rows, input, ADDR_L+1; number of rows to load, sampled with start.
REQ-009 SHALL have port busy, output, 1; high while not in IDLE.
REQ-010 SHALL have port done, output, 1; one-cycle pulse at load completion.
REQ-011 SHALL have port mem_rd_en, output, 1; data-memory read strobe.
REQ-012 SHALL have port mem_rd_addr, output, ADDR_L; data-memory row address.
REQ-013 SHALL have port mem_rd_data, input, mem_word_t; read data, valid RD_LAT cycles after mem_rd_en.
REQ-014 SHALL have port out_vld, output, 1; a row is presented to the register-bank write stage.
REQ-015 SHALL have port out_rdy, input, 1; the register-bank write stage accepts the row.
REQ-016 SHALL have port out_data, output, mem_word_t; row data, lane b goes to bank b.
REQ-017 SHALL have port out_idx, output, ADDR_L; row offset from base_addr, starting at 0.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, DRAIN, FIN; IDLE->ISSUE on start with n_rows>0; IDLE->FIN on start with n_rows=0; ISSUE->DRAIN when the last read is issued; DRAIN->FIN when the last row is accepted; FIN->IDLE unconditionally.
REQ-019 SHALL assert done only in FIN, for exactly one cycle; n_rows=0 SHALL issue no read and pulse done 2 cycles after start.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL drive mem_rd_en in ISSUE only when (fifo_count + in_flight - pop) < FIFO_DEPTH, where pop is the out_vld&out_rdy of the same cycle.
REQ-022 SHALL drive mem_rd_addr = (base_addr + issued_count) mod 2^ADDR_L; the address SHALL wrap from 2^ADDR_L-1 to 0.
REQ-023 SHALL track in-flight reads with an RD_LAT-deep valid shift register and SHALL write mem_rd_data into the FIFO in the cycle its valid bit emerges.
REQ-024 SHALL present the FIFO head on out_data and out_vld from a registered FIFO, so that row i is visible RD_LAT+1 cycles after its mem_rd_en.
REQ-025 SHALL hold out_data and out_idx stable while out_vld=1 and out_rdy=0.
REQ-026 SHALL transfer a row only when out_vld&out_rdy; out_idx SHALL increase by 1 per transfer.
REQ-027 SHALL sustain one row per cycle with out_rdy held at 1.
REQ-028 SHALL never overflow or underflow the FIFO under any out_rdy pattern.
REQ-029 SHALL handle a simultaneous FIFO push and pop in one cycle with the count unchanged.

Reset
REQ-030 SHALL on rst put the FSM in IDLE and set busy, done, mem_rd_en, out_vld, mem_rd_addr, out_idx, counters, and in-flight bits to 0.
REQ-031 SHALL discard in-flight read data and FIFO contents when rst asserts mid-load; out_data contents SHALL not be reset.

Structure
REQ-032 SHALL take mem_word_t, BIT_L, N_BANKS, DATA_MEM_ADDR_L, and DATA_MEM_RD_LATENCY from hw_config_pkg.
REQ-033 SHALL add LOADER_FIFO_DEPTH and typedef mem_addr_t (logic [DATA_MEM_ADDR_L-1:0]) to hw_config_pkg.
REQ-034 SHALL put the buffer in one sub-module, mem_word_fifo (synchronous, parameterised depth, registered outputs).

Verification
REQ-035 SHALL cover this case: base=0x10, n_rows=4, out_rdy=1 -> addresses 0x10..0x13 on 4 consecutive cycles, out_idx 0..3 consecutive, then done one cycle after the last transfer.
REQ-036 SHALL cover this case: base=2^ADDR_L-2, n_rows=4 -> addresses wrap as max-1, max, 0, 1.
REQ-037 SHALL cover this case: n_rows=8, out_rdy=0 for 20 cycles then 1 -> exactly FIFO_DEPTH reads issued before the stall releases, no data loss, 8 ordered rows.
REQ-038 SHALL cover this case: n_rows=0 -> no mem_rd_en, done 2 cycles after start; a start held high while busy -> no second load.
REQ-039 SHALL cover this case: rst asserted 3 cycles into an n_rows=16 load -> all outputs 0 immediately; a subsequent load with n_rows=2 returns only new data.
REQ-040 SHALL cover this case: random out_rdy at 50% with n_rows=100 -> scoreboard matches all 100 rows in order, done exactly once.
